psum_collector: RTL and testbench

- Sits at the bottom of each systolic column and consumes the partial-sum stream leaving the last PE row: Psum, Addr_P and Valid_P.
- Accumulates each incoming partial sum into an on-chip accumulator bank, indexed by Addr_P, with saturation.
- On command, drains the bank in address order over a valid/ready stream to the output writer, clearing each entry as it is read.

---
 rtl/psum_collector.sv | 144 ++++++++++++++
 tb/tb_psum_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// psum_collector: per-column accumulator bank fed by the last PE row,
// saturating read-modify-write, drained in address order over valid/ready.
module psum_collector #(
    parameter int PSUM_W  = 32,
    parameter int ACC_W   = 40,
    parameter int ADDR_W  = 8,
    parameter int VALID_W = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic signed [PSUM_W-1:0] Psum_In,
    input  logic [ADDR_W-1:0]        Addr_P_In,
    input  logic [VALID_W-1:0]       Valid_P_In,
    input  logic                     Drain_Start,
    input  logic [ADDR_W:0]          Drain_Len,
    output logic signed [ACC_W-1:0]  Out_Data,
    output logic [ADDR_W-1:0]        Out_Addr,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Ovf,
    output logic                     Drop_Err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic signed [ACC_W-1:0]  acc [DEPTH];
    logic                     s1_vld;
    logic                     s1_clr;
    logic [ADDR_W-1:0]        s1_addr;
    logic signed [PSUM_W-1:0] s1_psum;
    logic [ADDR_W:0]          len_q;
    logic [ADDR_W-1:0]        ptr;

    logic signed [ACC_W-1:0]  psum_ext;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W-1:0]  wr_val;
    logic                     wr_ovf;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [ACC_W-1:0]  rd_data;
    logic                     accept;
    logic                     last;

    assign accept = Out_Valid & Out_Ready;
    assign last   = ({1'b0, ptr} == len_q - 1'b1);
    assign Busy   = (state != IDLE);
    assign Done   = (state == DONE);

    // Stage 2: widen by one bit so overflow shows up as a sign mismatch
    always_comb begin
        psum_ext = ACC_W'(s1_psum);
        sum      = (ACC_W+1)'(acc[s1_addr]) + (ACC_W+1)'(psum_ext);
        wr_ovf   = 1'b0;
        wr_val   = sum[ACC_W-1:0];
        if (s1_clr) begin
            wr_val = psum_ext;
        end else if (sum[ACC_W] != sum[ACC_W-1]) begin
            wr_ovf = 1'b1;
            wr_val = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Next beat to present; forward the write landing on the same edge
    always_comb begin
        rd_addr = (state == DRAIN) ? ptr + 1'b1 : '0;
        if (s1_vld && s1_addr == rd_addr) rd_data = wr_val;
        else                              rd_data = acc[rd_addr];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (Drain_Start) state_nx = FLUSH;
            FLUSH: state_nx = (len_q == '0) ? DONE : DRAIN;
            DRAIN: if (accept && last) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld    <= 1'b0;
            s1_clr    <= 1'b0;
            s1_addr   <= '0;
            s1_psum   <= '0;
            len_q     <= '0;
            ptr       <= '0;
            Out_Valid <= 1'b0;
            Out_Addr  <= '0;
            Out_Data  <= '0;
            Ovf       <= 1'b0;
            Drop_Err  <= 1'b0;
        end else begin
            s1_vld  <= (state == IDLE) && Valid_P_In[0];
            s1_clr  <= Valid_P_In[1];
            s1_addr <= Addr_P_In;
            s1_psum <= Psum_In;
            if (state != IDLE && Valid_P_In[0]) Drop_Err <= 1'b1;
            if (s1_vld && wr_ovf) Ovf <= 1'b1;
            if (state == IDLE && Drain_Start)
                len_q <= (Drain_Len > MAX_LEN) ? MAX_LEN : Drain_Len;
            if (state == FLUSH && len_q != '0) begin
                Out_Valid <= 1'b1;
                Out_Addr  <= '0;
                Out_Data  <= rd_data;
                ptr       <= '0;
            end
            if (state == DRAIN && accept) begin
                if (last) begin
                    Out_Valid <= 1'b0;
                end else begin
                    ptr      <= ptr + 1'b1;
                    Out_Addr <= ptr + 1'b1;
                    Out_Data <= rd_data;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
        end else if (s1_vld) begin
            acc[s1_addr] <= wr_val;
        end else if (state == DRAIN && accept) begin
            acc[ptr] <= '0;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed stimulus with a beat scoreboard checked
// by an independent monitor on the drain port.
module tb_psum_collector;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic signed [31:0] Psum_In = '0;
    logic [7:0]         Addr_P_In = '0;
    logic [1:0]         Valid_P_In = '0;
    logic               Drain_Start = 1'b0;
    logic [8:0]         Drain_Len = '0;
    logic signed [39:0] Out_Data;
    logic [7:0]         Out_Addr;
    logic               Out_Valid;
    logic               Out_Ready = 1'b0;
    logic               Busy;
    logic               Done;
    logic               Ovf;
    logic               Drop_Err;

    psum_collector dut (
        .CLK(CLK), .RST(RST),
        .Psum_In(Psum_In), .Addr_P_In(Addr_P_In), .Valid_P_In(Valid_P_In),
        .Drain_Start(Drain_Start), .Drain_Len(Drain_Len),
        .Out_Data(Out_Data), .Out_Addr(Out_Addr), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Busy(Busy), .Done(Done),
        .Ovf(Ovf), .Drop_Err(Drop_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        longint addr;
        longint data;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  e;
    int     vectors = 0;
    int     miscompares = 0;
    bit     prev_stall = 0;
    longint prev_addr = 0;
    longint prev_data = 0;
    bit     pat [6] = '{0, 0, 1, 0, 1, 1};

    localparam logic signed [31:0] PMAX = 32'sh7fff_ffff;
    localparam logic signed [31:0] PMIN = 32'sh8000_0000;

    task automatic chk(input string nm, input longint act, input longint expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic push(input longint a, input longint d);
        exp_q.push_back('{a, d});
    endtask

    task automatic feed(input int a, input logic signed [31:0] p,
                        input logic [1:0] v);
        Addr_P_In  = 8'(a);
        Psum_In    = p;
        Valid_P_In = v;
        @(posedge CLK); #1;
        Valid_P_In = '0;
    endtask

    task automatic drain(input int len, input int nexp,
                         input bit use_pat, input bit inj);
        int cyc, beats, idx, acc_cyc, done_cyc;
        bit done_seen;
        Drain_Len   = 9'(len);
        Drain_Start = 1'b1;
        @(posedge CLK); #1;
        Drain_Start = 1'b0;
        Valid_P_In  = '0;
        cyc = 0; beats = 0; idx = 0;
        acc_cyc = -1; done_cyc = -1; done_seen = 0;
        while (!done_seen && cyc < 1000) begin
            if (Out_Valid) begin
                Out_Ready = use_pat ? ((idx < 6) ? pat[idx] : 1'b1) : 1'b1;
                if (inj && idx == 0) begin
                    Valid_P_In  = 2'b01;
                    Addr_P_In   = 8'd5;
                    Psum_In     = 32'sd100;
                    Drain_Start = 1'b1;
                    Drain_Len   = 9'd9;
                end
                idx++;
            end else begin
                Out_Ready = 1'b0;
            end
            @(negedge CLK);
            if (Out_Valid && Out_Ready) begin
                beats++;
                acc_cyc = cyc;
            end
            if (Done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            @(posedge CLK); #1;
            Valid_P_In  = '0;
            Drain_Start = 1'b0;
            cyc++;
        end
        Out_Ready = 1'b0;
        chk("drain_done_seen", done_seen, 1);
        chk("drain_beats", beats, nexp);
        if (nexp > 0) chk("done_latency", done_cyc - acc_cyc, 1);
        chk("exp_q_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge CLK);
        chk("done_one_cycle", Done, 0);
        chk("busy_after_done", Busy, 0);
        @(posedge CLK); #1;
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", Out_Valid, 1);
                chk("stall_addr", Out_Addr, prev_addr);
                chk("stall_data", Out_Data, prev_data);
            end
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", Out_Addr, e.addr);
                    chk("beat_data", Out_Data, e.data);
                end
            end
            prev_stall = Out_Valid && !Out_Ready;
            prev_addr  = Out_Addr;
            prev_data  = Out_Data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, cyc;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_out_data", Out_Data, 0);
        chk("rst_out_addr", Out_Addr, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_ovf", Ovf, 0);
        chk("rst_drop_err", Drop_Err, 0);

        feed(3, 32'sd5, 2'b11);
        feed(3, -32'sd2, 2'b01);
        feed(3, 32'sd10, 2'b01);
        push(0, 0); push(1, 0); push(2, 0); push(3, 13);
        drain(4, 4, 0, 0);
        for (int i = 0; i < 4; i++) push(i, 0);
        drain(4, 4, 0, 0);

        feed(0, 32'sd1, 2'b11);
        feed(1, 32'sd2, 2'b11);
        feed(0, 32'sd3, 2'b01);
        feed(1, 32'sd4, 2'b01);
        Addr_P_In  = 8'd0;
        Psum_In    = 32'sd9;
        Valid_P_In = 2'b01;
        push(0, 13); push(1, 6);
        drain(2, 2, 0, 0);

        chk("ovf_before_sat", Ovf, 0);
        feed(7, PMAX, 2'b11);
        repeat (300) feed(7, PMAX, 2'b01);
        @(posedge CLK); #1;
        chk("ovf_pos_sat", Ovf, 1);
        for (int i = 0; i < 7; i++) push(i, 0);
        push(7, 40'sh7f_ffff_ffff);
        drain(8, 8, 0, 0);
        feed(7, PMIN, 2'b11);
        repeat (300) feed(7, PMIN, 2'b01);
        for (int i = 0; i < 7; i++) push(i, 0);
        push(7, -(64'sd1 <<< 39));
        drain(8, 8, 0, 0);

        feed(0, 32'sd11, 2'b11);
        feed(1, 32'sd22, 2'b11);
        feed(2, 32'sd33, 2'b11);
        push(0, 11); push(1, 22); push(2, 33);
        drain(3, 3, 1, 0);

        chk("drop_err_before", Drop_Err, 0);
        feed(1, 32'sd50, 2'b11);
        feed(0, 32'sd40, 2'b11);
        push(0, 40); push(1, 50);
        drain(2, 2, 0, 1);
        chk("drop_err_set", Drop_Err, 1);
        for (int i = 0; i < 8; i++) push(i, 0);
        drain(8, 8, 0, 0);

        drain(0, 0, 0, 0);

        for (int i = 0; i < 256; i++) push(i, 0);
        drain(300, 256, 0, 0);

        for (int i = 0; i < 5; i++) begin
            feed(i, 32'(i + 1), 2'b11);
            push(i, i + 1);
        end
        Drain_Len   = 9'd5;
        Drain_Start = 1'b1;
        @(posedge CLK); #1;
        Drain_Start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 100) begin
            Out_Ready = Out_Valid;
            @(negedge CLK);
            if (Out_Valid && Out_Ready) beats++;
            @(posedge CLK); #1;
            cyc++;
        end
        chk("abort_beats", beats, 2);
        RST = 1'b1;
        Out_Ready = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete();
        chk("abort_out_valid", Out_Valid, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        for (int i = 0; i < 5; i++) push(i, 0);
        drain(5, 5, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
